// File: rtl/ddr3_frame_reader.sv
// Avalon-MM burstless read master that fetches one 8-bit grayscale frame from DDR3
// and unpacks each returned word, byte 0 first, into a byte-wide FIFO write stream.
module ddr3_frame_reader #(
    parameter int WIDTH           = 1280,
    parameter int HEIGHT          = 720,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic [7:0]        out_din
);
    localparam int BYTES  = DATA_W / 8;
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int WORDS  = PIXELS / BYTES;
    localparam int WC_W   = $clog2(WORDS + 1);
    localparam int PC_W   = $clog2(PIXELS + 1);
    localparam int BI_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    if ((PIXELS % BYTES) != 0 || (DATA_W % 8) != 0) begin : g_size_check
        $error("ddr3_frame_reader: frame must be a whole number of bus words");
    end

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   req_cnt_q, req_cnt_d;
    logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] mem_q [MAX_OUTSTANDING];
    logic [DATA_W-1:0] mem_d [MAX_OUTSTANDING];

    logic             accept, push, pop, credit_ok;
    logic [CNT_W:0]   in_use;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Reads in flight plus words still buffered never exceed the buffer depth,
        // so every returning word is guaranteed a slot.
        in_use    = {1'b0, outst_q} + {1'b0, count_q};
        credit_ok = in_use < (CNT_W + 1)'(MAX_OUTSTANDING);

        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        avm_read    = (state_q == READ) && credit_ok;
        avm_address = addr_q;
        out_wr_en   = (count_q != '0) && !out_full;
        out_din     = mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: 8];

        accept = avm_read && !avm_waitrequest;
        push   = avm_readdatavalid && (state_q != IDLE);
        pop    = out_wr_en && (byte_idx_q == BI_W'(BYTES - 1));

        state_d    = state_q;
        addr_d     = addr_q;
        req_cnt_d  = req_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        byte_idx_d = byte_idx_q;
        mem_d      = mem_q;
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            mem_d[wr_ptr_q] = avm_readdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (out_wr_en) begin
            byte_idx_d = pop ? '0 : byte_idx_q + 1'b1;
            pix_cnt_d  = pix_cnt_q + 1'b1;
        end
        if (accept) begin
            addr_d    = addr_q + ADDR_W'(BYTES);
            req_cnt_d = req_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    addr_d    = base_addr;
                    req_cnt_d = '0;
                    pix_cnt_d = '0;
                end
            end
            READ: begin
                if (accept && req_cnt_q == WC_W'(WORDS - 1)) state_d = FLUSH;
            end
            FLUSH: begin
                if (out_wr_en && pix_cnt_q == PC_W'(PIXELS - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            req_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            outst_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            byte_idx_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_cnt_q  <= req_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            byte_idx_q <= byte_idx_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Directed bench for ddr3_frame_reader: dut0 reads an 8x2 frame, dut1 a 64x1 frame;
// an Avalon slave model returns bytes equal to the low address byte plus lane.
module tb_ddr3_frame_reader;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    start, frame_clr, out_full;
    logic [AW-1:0] base_addr [2];
    logic [1:0]    busy, done, avm_read, out_wr_en;
    logic [1:0]    avm_waitrequest, avm_readdatavalid;
    logic [AW-1:0] avm_address [2];
    logic [DW-1:0] avm_readdata [2];
    logic [7:0]    out_din [2];

    int lat [2];
    int wr_hold_len [2];

    always #5 clock = ~clock;

    ddr3_frame_reader #(.WIDTH(8), .HEIGHT(2), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4)) dut0 (
        .clock(clock), .reset(reset), .start(start[0]), .base_addr(base_addr[0]),
        .busy(busy[0]), .done(done[0]), .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]),
        .avm_readdatavalid(avm_readdatavalid[0]), .out_wr_en(out_wr_en[0]),
        .out_full(out_full[0]), .out_din(out_din[0]));

    ddr3_frame_reader #(.WIDTH(64), .HEIGHT(1), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]), .base_addr(base_addr[1]),
        .busy(busy[1]), .done(done[1]), .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]),
        .avm_readdatavalid(avm_readdatavalid[1]), .out_wr_en(out_wr_en[1]),
        .out_full(out_full[1]), .out_din(out_din[1]));

    // Slave model and monitor state, written only by the monitor process.
    int            cyc;
    int            pq_head [2], pq_tail [2];
    logic [AW-1:0] pq_addr [2][16];
    int            pq_due  [2][16];
    int            cap_n [2], acc_n [2], done_n [2], hold_cnt [2];
    logic [7:0]    cap [2][64];
    logic [AW-1:0] rd_addr [2][16];
    int            credit_err [2], full_err [2], hold_err [2], acc_before_valid [2], max_infl [2];
    logic          seen_valid [2], prev_wait [2];
    logic [AW-1:0] prev_addr [2];
    int            first_valid_cyc [2], first_wr_cyc [2], last_wr_cyc [2], done_cyc [2];

    function automatic logic [DW-1:0] mkword(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 8; k++) w[8*k +: 8] = a[7:0] + 8'(k);
        return w;
    endfunction

    task automatic clear_stats(input int g);
        cap_n[g] = 0; acc_n[g] = 0; done_n[g] = 0; hold_cnt[g] = 0;
        credit_err[g] = 0; full_err[g] = 0; hold_err[g] = 0;
        acc_before_valid[g] = 0; max_infl[g] = 0; seen_valid[g] = 1'b0;
        first_valid_cyc[g] = -1; first_wr_cyc[g] = -1; last_wr_cyc[g] = -1; done_cyc[g] = -1;
    endtask

    initial begin
        int infl;
        cyc = 0;
        avm_waitrequest = '0;
        avm_readdatavalid = '0;
        for (int g = 0; g < 2; g++) begin
            pq_head[g] = 0; pq_tail[g] = 0; prev_wait[g] = 1'b0; prev_addr[g] = '0;
            avm_readdata[g] = '0;
            clear_stats(g);
        end
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                if (reset) begin
                    pq_head[g] = 0; pq_tail[g] = 0; prev_wait[g] = 1'b0;
                    avm_readdatavalid[g] = 1'b0; avm_waitrequest[g] = 1'b0;
                end else begin
                    if (frame_clr[g]) clear_stats(g);
                    if (pq_head[g] != pq_tail[g] && pq_due[g][pq_head[g] % 16] <= cyc) begin
                        avm_readdatavalid[g] = 1'b1;
                        avm_readdata[g] = mkword(pq_addr[g][pq_head[g] % 16]);
                        pq_head[g]++;
                        if (!seen_valid[g]) begin seen_valid[g] = 1'b1; first_valid_cyc[g] = cyc; end
                    end else begin
                        avm_readdatavalid[g] = 1'b0;
                    end
                    avm_waitrequest[g] = avm_read[g] && (hold_cnt[g] < wr_hold_len[g]);
                    if (avm_waitrequest[g]) hold_cnt[g]++;
                    if (prev_wait[g] && !(avm_read[g] === 1'b1 && avm_address[g] === prev_addr[g]))
                        hold_err[g]++;
                    infl = acc_n[g] - cap_n[g] / 8;
                    if (avm_read[g] && infl >= 4) credit_err[g]++;
                    if (avm_read[g] && !avm_waitrequest[g]) begin
                        pq_addr[g][pq_tail[g] % 16] = avm_address[g];
                        pq_due[g][pq_tail[g] % 16] = cyc + lat[g];
                        pq_tail[g]++;
                        if (acc_n[g] < 16) rd_addr[g][acc_n[g]] = avm_address[g];
                        acc_n[g]++;
                        if (!seen_valid[g]) acc_before_valid[g]++;
                        if (infl + 1 > max_infl[g]) max_infl[g] = infl + 1;
                    end
                    if (out_wr_en[g]) begin
                        if (out_full[g]) full_err[g]++;
                        if (cap_n[g] < 64) cap[g][cap_n[g]] = out_din[g];
                        if (cap_n[g] == 0) first_wr_cyc[g] = cyc;
                        cap_n[g]++;
                        last_wr_cyc[g] = cyc;
                    end
                    if (done[g]) begin done_n[g]++; done_cyc[g] = cyc; end
                    prev_wait[g] = avm_waitrequest[g];
                    prev_addr[g] = avm_address[g];
                end
            end
            cyc++;
        end
    end

    int n_assert, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic begin_frame(input int g, input logic [AW-1:0] addr);
        @(posedge clock); #1;
        start[g] = 1'b1; frame_clr[g] = 1'b1; base_addr[g] = addr;
        @(posedge clock); #1;
        start[g] = 1'b0; frame_clr[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string tag);
        int n;
        n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done[g]), 64'd1);
    endtask

    task automatic check_bytes(input int g, input string tag, input int n, input logic [7:0] b0);
        logic [7:0] e;
        chk({tag, "_nbytes"}, 64'(cap_n[g]), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = b0 + 8'(i);
            chk($sformatf("%s_byte%0d", tag, i), 64'(cap[g][i]), 64'(e));
        end
    endtask

    task automatic check_idle_outputs(input int g, input string tag);
        chk({tag, "_ctl"}, 64'({busy[g], done[g], avm_read[g], out_wr_en[g]}), 64'd0);
        chk({tag, "_addr"}, 64'(avm_address[g]), 64'd0);
        chk({tag, "_din"}, 64'(out_din[g]), 64'd0);
    endtask

    initial begin
        int n;
        n_assert = 0; n_fail = 0;
        reset = 1'b1; start = '0; frame_clr = '0; out_full = '0;
        base_addr[0] = '0; base_addr[1] = '0;
        lat[0] = 1; lat[1] = 1; wr_hold_len[0] = 0; wr_hold_len[1] = 0;

        tick(3);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        reset = 1'b0;
        tick(2);

        // Test 1: zero-wait slave, 8x2 frame
        begin_frame(0, 32'h1000);
        chk("t1_read_lat", 64'(avm_read[0]), 64'd1);
        chk("t1_addr0", 64'(avm_address[0]), 64'h1000);
        wait_done(0, 100, "t1");
        chk("t1_busy_in_done", 64'(busy[0]), 64'd1);
        tick(1);
        chk("t1_busy_after", 64'(busy[0]), 64'd0);
        chk("t1_done_after", 64'(done[0]), 64'd0);
        chk("t1_done_lat", 64'(done_cyc[0] - last_wr_cyc[0]), 64'd1);
        chk("t1_wr_lat", 64'(first_wr_cyc[0] - first_valid_cyc[0]), 64'd1);
        chk("t1_sustained", 64'(last_wr_cyc[0] - first_wr_cyc[0]), 64'd15);
        chk("t1_nreads", 64'(acc_n[0]), 64'd2);
        chk("t1_rd0", 64'(rd_addr[0][0]), 64'h1000);
        chk("t1_rd1", 64'(rd_addr[0][1]), 64'h1008);
        tick(3);
        chk("t1_done_once", 64'(done_n[0]), 64'd1);
        check_bytes(0, "t1", 16, 8'h00);

        // Test 2: waitrequest held 5 cycles on first read
        wr_hold_len[0] = 5;
        begin_frame(0, 32'h1000);
        tick(3);
        chk("t2_read_held", 64'(avm_read[0]), 64'd1);
        chk("t2_addr_held", 64'(avm_address[0]), 64'h1000);
        wait_done(0, 100, "t2");
        tick(1);
        chk("t2_hold_cycles", 64'(hold_cnt[0]), 64'd5);
        chk("t2_hold_err", 64'(hold_err[0]), 64'd0);
        chk("t2_nreads", 64'(acc_n[0]), 64'd2);
        chk("t2_rd1", 64'(rd_addr[0][1]), 64'h1008);
        check_bytes(0, "t2", 16, 8'h00);
        wr_hold_len[0] = 0;

        // Test 3: FIFO full for 20 cycles, 64x1 frame
        out_full[1] = 1'b1;
        begin_frame(1, 32'h4000);
        tick(18);
        chk("t3_no_wr_full", 64'(cap_n[1]), 64'd0);
        chk("t3_credit_stop", 64'(acc_n[1]), 64'd4);
        out_full[1] = 1'b0;
        wait_done(1, 300, "t3");
        tick(2);
        chk("t3_credit_err", 64'(credit_err[1]), 64'd0);
        chk("t3_full_err", 64'(full_err[1]), 64'd0);
        chk("t3_max_infl", 64'(max_infl[1]), 64'd4);
        chk("t3_nreads", 64'(acc_n[1]), 64'd8);
        chk("t3_rd7", 64'(rd_addr[1][7]), 64'h4038);
        chk("t3_done_once", 64'(done_n[1]), 64'd1);
        check_bytes(1, "t3", 64, 8'h00);

        // Test 4: 10-cycle slave latency, pipelined returns
        lat[1] = 10;
        begin_frame(1, 32'h8000);
        wait_done(1, 300, "t4");
        tick(2);
        chk("t4_b2b_before_valid", 64'(acc_before_valid[1]), 64'd4);
        chk("t4_credit_err", 64'(credit_err[1]), 64'd0);
        chk("t4_nreads", 64'(acc_n[1]), 64'd8);
        chk("t4_done_once", 64'(done_n[1]), 64'd1);
        check_bytes(1, "t4", 64, 8'h00);
        lat[1] = 1;

        // Test 5: start pulsed mid-frame and during the DONE cycle
        begin_frame(0, 32'h1000);
        tick(2);
        @(posedge clock); #1;
        start[0] = 1'b1; base_addr[0] = 32'h3000;
        @(posedge clock); #1;
        start[0] = 1'b0;
        wait_done(0, 100, "t5");
        start[0] = 1'b1; base_addr[0] = 32'h5000;
        @(posedge clock); #1;
        start[0] = 1'b0;
        chk("t5_start_in_done", 64'(busy[0]), 64'd0);
        tick(5);
        chk("t5_stay_idle", 64'(busy[0]), 64'd0);
        chk("t5_nreads", 64'(acc_n[0]), 64'd2);
        chk("t5_rd0", 64'(rd_addr[0][0]), 64'h1000);
        chk("t5_rd1", 64'(rd_addr[0][1]), 64'h1008);
        chk("t5_done_once", 64'(done_n[0]), 64'd1);
        check_bytes(0, "t5", 16, 8'h00);

        // Test 6: reset after first word returned, then a clean frame
        begin_frame(0, 32'h1000);
        n = 0;
        while (!seen_valid[0] && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("t6_first_word", 64'(seen_valid[0]), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs(0, "t6_rst");
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("t6_no_done", 64'(done_n[0]), 64'd0);
        chk("t6_idle", 64'(busy[0]), 64'd0);
        begin_frame(0, 32'h2040);
        chk("t6_new_addr", 64'(avm_address[0]), 64'h2040);
        wait_done(0, 100, "t6");
        tick(2);
        chk("t6_nreads", 64'(acc_n[0]), 64'd2);
        chk("t6_rd1", 64'(rd_addr[0][1]), 64'h2048);
        chk("t6_done_once", 64'(done_n[0]), 64'd1);
        check_bytes(0, "t6", 16, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
